// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter sharing one memory slave port between instruction and data masters.
// Latency: master valid at cycle N gives mem_valid at N+1; the slave response is forwarded combinationally.
// Backpressure: one request per master is held in a pending slot; one slave transaction is outstanding at a time.
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,

    input  logic        imemory_valid,
    input  logic        imemory_instr,
    input  logic [31:0] imemory_addr,
    input  logic [31:0] imemory_wdata,
    input  logic [3:0]  imemory_wstrb,
    output logic [31:0] imemory_rdata,
    output logic        imemory_ready,

    input  logic        dmemory_valid,
    input  logic        dmemory_instr,
    input  logic [31:0] dmemory_addr,
    input  logic [31:0] dmemory_wdata,
    input  logic [3:0]  dmemory_wstrb,
    output logic [31:0] dmemory_rdata,
    output logic        dmemory_ready,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,

    output logic        busy
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_t state_q, state_d;
    owner_t owner_q, owner_d;
    logic   last_is_d_q, last_is_d_d;

    logic   i_pend_q, i_pend_d;
    logic   d_pend_q, d_pend_d;
    req_t   i_slot_q, i_slot_d;
    req_t   d_slot_q, d_slot_d;

    logic   mem_valid_q, mem_valid_d;
    req_t   mem_req_q, mem_req_d;

    req_t   i_req_in, d_req_in;
    req_t   i_cand_req, d_cand_req;
    logic   i_accept, d_accept;
    logic   i_cand, d_cand;
    logic   rsp_done, arb_en;
    logic   grant_i, grant_d;

    assign i_req_in = {imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb};
    assign d_req_in = {dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb};

    // A master already pending or owning the slave has broken the protocol; drop its valid.
    assign i_accept = imemory_valid && !i_pend_q && (owner_q != OWN_I);
    assign d_accept = dmemory_valid && !d_pend_q && (owner_q != OWN_D);

    assign i_cand     = i_pend_q || i_accept;
    assign d_cand     = d_pend_q || d_accept;
    assign i_cand_req = i_pend_q ? i_slot_q : i_req_in;
    assign d_cand_req = d_pend_q ? d_slot_q : d_req_in;

    assign rsp_done = (state_q == ST_BUSY) && mem_ready && (owner_q != OWN_NONE);
    assign arb_en   = (state_q == ST_IDLE) || rsp_done;

    // On a tie the master that was not granted last wins.
    assign grant_i = arb_en && i_cand && (!d_cand || last_is_d_q);
    assign grant_d = arb_en && d_cand && (!i_cand || !last_is_d_q);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_is_d_d = last_is_d_q;
        mem_valid_d = 1'b0;
        mem_req_d   = mem_req_q;
        i_pend_d    = i_pend_q;
        i_slot_d    = i_slot_q;
        d_pend_d    = d_pend_q;
        d_slot_d    = d_slot_q;

        if (grant_i) begin
            mem_valid_d = 1'b1;
            mem_req_d   = i_cand_req;
            owner_d     = OWN_I;
            last_is_d_d = 1'b0;
            state_d     = ST_BUSY;
        end else if (grant_d) begin
            mem_valid_d = 1'b1;
            mem_req_d   = d_cand_req;
            owner_d     = OWN_D;
            last_is_d_d = 1'b1;
            state_d     = ST_BUSY;
        end else if (rsp_done) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
        end

        if (grant_i) begin
            i_pend_d = 1'b0;
        end else if (i_accept) begin
            i_pend_d = 1'b1;
            i_slot_d = i_req_in;
        end

        if (grant_d) begin
            d_pend_d = 1'b0;
        end else if (d_accept) begin
            d_pend_d = 1'b1;
            d_slot_d = d_req_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            last_is_d_q <= 1'b0;
            i_pend_q    <= 1'b0;
            d_pend_q    <= 1'b0;
            i_slot_q    <= '0;
            d_slot_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_req_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_is_d_q <= last_is_d_d;
            i_pend_q    <= i_pend_d;
            d_pend_q    <= d_pend_d;
            i_slot_q    <= i_slot_d;
            d_slot_q    <= d_slot_d;
            mem_valid_q <= mem_valid_d;
            mem_req_q   <= mem_req_d;
        end
    end

    assign imemory_ready = rsp_done && (owner_q == OWN_I);
    assign dmemory_ready = rsp_done && (owner_q == OWN_D);
    assign imemory_rdata = imemory_ready ? mem_rdata : 32'h0;
    assign dmemory_rdata = dmemory_ready ? mem_rdata : 32'h0;

    assign mem_valid = mem_valid_q;
    assign mem_instr = mem_req_q.instr;
    assign mem_addr  = mem_req_q.addr;
    assign mem_wdata = mem_req_q.wdata;
    assign mem_wstrb = mem_req_q.wstrb;

    assign busy = (state_q == ST_BUSY) || mem_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imemory_valid, imemory_instr;
    logic [31:0] imemory_addr, imemory_wdata;
    logic [3:0]  imemory_wstrb;
    logic [31:0] imemory_rdata;
    logic        imemory_ready;
    logic        dmemory_valid, dmemory_instr;
    logic [31:0] dmemory_addr, dmemory_wdata;
    logic [3:0]  dmemory_wstrb;
    logic [31:0] dmemory_rdata;
    logic        dmemory_ready;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .imemory_valid (imemory_valid),
        .imemory_instr (imemory_instr),
        .imemory_addr  (imemory_addr),
        .imemory_wdata (imemory_wdata),
        .imemory_wstrb (imemory_wstrb),
        .imemory_rdata (imemory_rdata),
        .imemory_ready (imemory_ready),
        .dmemory_valid (dmemory_valid),
        .dmemory_instr (dmemory_instr),
        .dmemory_addr  (dmemory_addr),
        .dmemory_wdata (dmemory_wdata),
        .dmemory_wstrb (dmemory_wstrb),
        .dmemory_rdata (dmemory_rdata),
        .dmemory_ready (dmemory_ready),
        .mem_valid     (mem_valid),
        .mem_instr     (mem_instr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .busy          (busy)
    );

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: master 0 = instruction port, 1 = data port, -1 = nobody.
    bit   m_pend [2];
    req_t m_slot [2];
    int   m_owner;
    int   m_last;
    bit   m_busy;
    bit   m_mv;
    req_t m_out;
    bit   issued_instr[$];

    task automatic model_reset();
        m_pend[0] = 0;
        m_pend[1] = 0;
        m_owner   = -1;
        m_last    = 0;
        m_busy    = 0;
        m_mv      = 0;
        m_out     = '0;
    endtask

    function automatic req_t in_req(input int m);
        if (m == 0) return {imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb};
        return {dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb};
    endfunction

    function automatic bit in_valid(input int m);
        return (m == 0) ? imemory_valid : dmemory_valid;
    endfunction

    task automatic clear_inputs();
        imemory_valid = 0; imemory_instr = 0; imemory_addr = 0; imemory_wdata = 0; imemory_wstrb = 0;
        dmemory_valid = 0; dmemory_instr = 0; dmemory_addr = 0; dmemory_wdata = 0; dmemory_wstrb = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    // Inputs are already driven; check this cycle, advance the model, return just after the next edge.
    task automatic step();
        bit   exp_ir, exp_dr, completing, granted;
        int   cands[$];
        req_t arr [2];
        bit   arrived [2];
        int   g;
        @(negedge clock);
        exp_ir = m_busy && (m_owner == 0) && mem_ready;
        exp_dr = m_busy && (m_owner == 1) && mem_ready;
        check_val("imemory_ready", 32'(imemory_ready), 32'(exp_ir));
        check_val("dmemory_ready", 32'(dmemory_ready), 32'(exp_dr));
        check_val("imemory_rdata", imemory_rdata, exp_ir ? mem_rdata : 32'h0);
        check_val("dmemory_rdata", dmemory_rdata, exp_dr ? mem_rdata : 32'h0);
        check_val("mem_valid", 32'(mem_valid), 32'(m_mv));
        check_val("busy", 32'(busy), 32'(m_busy));
        check_val("mem_instr", 32'(mem_instr), 32'(m_out.instr));
        check_val("mem_addr", mem_addr, m_out.addr);
        check_val("mem_wdata", mem_wdata, m_out.wdata);
        check_val("mem_wstrb", 32'(mem_wstrb), 32'(m_out.wstrb));
        if (mem_valid) issued_instr.push_back(mem_instr);

        completing = m_busy && mem_ready;
        granted    = 0;
        g          = -1;
        for (int m = 0; m < 2; m++) begin
            arrived[m] = 0;
            arr[m]     = '0;
            if (m_pend[m]) begin
                cands.push_back(m);
                arr[m] = m_slot[m];
            end else if (in_valid(m) && m_owner != m) begin
                cands.push_back(m);
                arr[m]     = in_req(m);
                arrived[m] = 1;
            end
        end
        m_mv = 0;
        if (!m_busy || completing) begin
            if (cands.size() == 0) begin
                m_busy  = 0;
                m_owner = -1;
            end else begin
                g       = (cands.size() == 2) ? 1 - m_last : cands[0];
                granted = 1;
                m_out   = arr[g];
                m_mv    = 1;
                m_owner = g;
                m_last  = g;
                m_busy  = 1;
                m_pend[g] = 0;
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (arrived[m] && !(granted && g == m)) begin
                m_pend[m] = 1;
                m_slot[m] = arr[m];
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 0;
        clear_inputs();
        #1;
        check_val("rst_mem_valid", 32'(mem_valid), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_imemory_ready", 32'(imemory_ready), 32'h0);
        check_val("rst_dmemory_ready", 32'(dmemory_ready), 32'h0);
        check_val("rst_mem_addr", mem_addr, 32'h0);
        check_val("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        model_reset();
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        model_reset();
        #3;
        do_reset();

        // Single instruction fetch.
        imemory_valid = 1; imemory_instr = 1; imemory_addr = 32'h100;
        step();
        clear_inputs();
        check_val("fetch_issue_valid", 32'(mem_valid), 32'h1);
        check_val("fetch_issue_addr", mem_addr, 32'h100);
        check_val("fetch_issue_instr", 32'(mem_instr), 32'h1);
        step();
        step();
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        check_val("fetch_rsp_ready", 32'(imemory_ready), 32'h1);
        check_val("fetch_rsp_rdata", imemory_rdata, 32'hDEADBEEF);
        check_val("fetch_rsp_d_ready", 32'(dmemory_ready), 32'h0);
        step();
        clear_inputs();
        step();
        mem_ready = 1; mem_rdata = 32'h12345678;   // stray response while idle
        step();
        clear_inputs();
        step();

        // Collision: data wins the first tie, instruction follows.
        do_reset();
        imemory_valid = 1; imemory_instr = 1; imemory_addr = 32'h10;
        dmemory_valid = 1; dmemory_addr = 32'h2000; dmemory_wdata = 32'h55; dmemory_wstrb = 4'hF;
        step();
        clear_inputs();
        check_val("coll_first_addr", mem_addr, 32'h2000);
        check_val("coll_first_wstrb", 32'(mem_wstrb), 32'hF);
        imemory_valid = 1; imemory_addr = 32'h999;  // illegal: instruction already pending
        step();
        clear_inputs();
        mem_ready = 1; mem_rdata = 32'hA5A5A5A5;
        #1;
        check_val("coll_d_ready", 32'(dmemory_ready), 32'h1);
        check_val("coll_i_not_ready", 32'(imemory_ready), 32'h0);
        step();
        clear_inputs();
        check_val("coll_second_valid", 32'(mem_valid), 32'h1);
        check_val("coll_second_addr", mem_addr, 32'h10);
        step();
        mem_ready = 1;
        step();
        clear_inputs();
        for (int k = 0; k < 3; k++) step();

        // Alternation: both masters re-request as soon as they are free.
        do_reset();
        issued_instr.delete();
        for (int c = 0; c < 60 && issued_instr.size() < 6; c++) begin
            clear_inputs();
            imemory_valid = !(m_pend[0] || m_owner == 0);
            imemory_instr = 1; imemory_addr = 32'h1000 + 32'(c);
            dmemory_valid = !(m_pend[1] || m_owner == 1);
            dmemory_addr  = 32'h2000 + 32'(c);
            mem_ready = m_busy && !m_mv;
            mem_rdata = 32'(c);
            step();
        end
        check_val("alt_issue_count", 32'(issued_instr.size()), 32'd6);
        for (int k = 0; k < 6 && k < issued_instr.size(); k++)
            check_val("alt_order", 32'(issued_instr[k]), 32'(k % 2));
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            mem_ready = m_busy && !m_mv;
            step();
        end

        // Back-to-back data requests with the instruction port idle.
        do_reset();
        for (int c = 0; c < 24; c++) begin
            clear_inputs();
            dmemory_valid = !(m_pend[1] || m_owner == 1);
            dmemory_addr  = 32'h3000 + 32'(c);
            dmemory_wstrb = 4'(c);
            mem_ready = m_busy && !m_mv && (c % 3 != 0);
            mem_rdata = 32'hC0DE0000 + 32'(c);
            step();
        end
        clear_inputs();

        // Reset while a transaction is outstanding.
        do_reset();
        imemory_valid = 1; imemory_instr = 1; imemory_addr = 32'h300;
        step();
        clear_inputs();
        step();
        do_reset();
        mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
        step();
        clear_inputs();
        imemory_valid = 1; imemory_addr = 32'h400;
        step();
        clear_inputs();
        check_val("post_rst_valid", 32'(mem_valid), 32'h1);
        check_val("post_rst_addr", mem_addr, 32'h400);
        step();
        mem_ready = 1;
        step();
        clear_inputs();

        // Random traffic, including illegal re-requests and stray responses.
        for (int c = 0; c < 3000; c++) begin
            imemory_valid = ($urandom % 4) == 0;
            imemory_instr = 1'($urandom);
            imemory_addr  = $urandom;
            imemory_wdata = $urandom;
            imemory_wstrb = 4'($urandom);
            dmemory_valid = ($urandom % 3) == 0;
            dmemory_instr = 1'($urandom);
            dmemory_addr  = $urandom;
            dmemory_wdata = $urandom;
            dmemory_wstrb = 4'($urandom);
            mem_ready     = !m_mv && (($urandom % 3) == 0);
            mem_rdata     = $urandom;
            step();
        end
        clear_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory slave port (bram) between the CPU instruction port and the CPU data port.
- Captures every request pulse into a per-master pending slot, so no request is dropped on collision.
- Issues one outstanding slave transaction at a time; round-robin between pending masters.
- Routes the slave response back to the master that owns the transaction.

Parameters:
- none (widths fixed: 32-bit address/data, 4-bit strobe)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
imemory_valid  in  1  instruction-port request pulse
imemory_instr  in  1  instruction-fetch flag
imemory_addr  in  32  request address
imemory_wdata  in  32  write data
imemory_wstrb  in  4  byte strobes; 0 = read
imemory_rdata  out  32  response data
imemory_ready  out  1  response pulse
dmemory_valid, dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb  in  1/1/32/32/4  data-port request, same semantics
dmemory_rdata  out  32  response data
dmemory_ready  out  1  response pulse
mem_valid  out  1  slave request pulse (registered)
mem_instr  out  1  slave instr flag (registered)
mem_addr  out  32  slave address (registered)
mem_wdata  out  32  slave write data (registered)
mem_wstrb  out  4  slave strobes (registered)
mem_rdata  in  32  slave response data
mem_ready  in  1  slave response pulse
busy  out  1  transaction outstanding

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - Both pending slots empty; state IDLE; owner NONE.
  - last_grant = I, so data wins the first tie.
- Pending slots:
  - imemory_valid=1 loads {instr,addr,wdata,wstrb} into slot I; likewise dmemory_valid loads slot D.
  - Each master holds at most one request in flight (pending or outstanding).
  - A valid from a master already pending or owning the slave is a protocol violation: ignored, slot unchanged.
- FSM IDLE:
  - Candidates = occupied slots plus requests arriving this cycle.
  - One candidate: grant it.
  - Two candidates: grant the master that is not last_grant.
  - On grant, the next cycle drives mem_valid=1 for exactly one cycle with the granted fields. Set owner, last_grant, state BUSY; free the slot.
  - Latency: master valid at cycle N gives mem_valid at N+1.
- FSM BUSY:
  - mem_valid=0; busy=1.
  - On mem_ready=1: drive the owner's *_ready=1 and *_rdata=mem_rdata combinationally in the same cycle; the non-owner sees ready=0, rdata=0.
  - In that same cycle, re-arbitrate among pending slots plus new arrivals, including a new request from the non-owner. A winner gives mem_valid at the next cycle (back-to-back, no idle bubble). No candidates: state IDLE, owner NONE.
- mem_ready while IDLE, or owner NONE: ignored, not forwarded.
- Request outputs mem_* hold their last values when mem_valid=0; slaves act only on mem_valid.
- busy = (state==BUSY) or mem_valid.
- Fairness:
  - Strict alternation whenever both masters are waiting.
  - A waiting master is served after at most one transaction of the other master.
- Reset mid-transaction:
  - Owner, slots and FSM cleared.
  - Any mem_ready arriving after reset release is ignored (owner NONE).

Test Plan:
- Single fetch: imemory_valid at cycle 1, addr=0x100 → mem_valid=1, mem_instr=1, mem_addr=0x100 at cycle 2. Slave mem_ready at cycle 4, rdata=0xDEADBEEF → imemory_ready=1, imemory_rdata=0xDEADBEEF at cycle 4; dmemory_ready=0.
- Collision: both valid at cycle 1 after reset (I addr 0x10, D write addr 0x2000, wstrb=0xF, wdata=0x55) → D issued cycle 2. Slave ready cycle 3 → I issued cycle 4, addr 0x10. dmemory_ready only at cycle 3, imemory_ready only at its own ready.
- Alternation: both masters re-request immediately after each ready for 6 transactions → mem issue order D,I,D,I,D,I; no bubble between ready and next mem_valid.
- Back-to-back same master: D requests at 1; I idle; D re-requests on the cycle after its ready → mem_valid exactly one cycle after the D valid each time; busy stays 1 only while outstanding.
- Stray/illegal: mem_ready pulse while IDLE → no *_ready asserted. Second dmemory_valid while D pending → ignored, only one D transaction issued.
- Reset mid-op: assert reset while BUSY, release, then slave ready → all outputs 0, no master ready. A subsequent imemory_valid is served normally with latency 1.
